// File: rtl/collector_pkg.sv
// Shared constants and the output slot type for the child response collector.
package collector_pkg;

    localparam int NUM_CHILD_DEF = 5;
    localparam int DATA_W_DEF    = 16;
    localparam int IDX_W_DEF     = $clog2(NUM_CHILD_DEF);
    localparam int CNT_W         = 16;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [IDX_W_DEF-1:0]  idx;
    } resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, then moves
// ptr just past the winner. Grants are suppressed while enable is low.
module rr_arbiter #(
    parameter int N     = 5,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   cand;
    logic             found;

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path can infer a latch.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if (enable && !found && req[cand[IDX_W-1:0]]) begin
                found                   = 1'b1;
                grant[cand[IDX_W-1:0]]  = 1'b1;
                grant_idx               = cand[IDX_W-1:0];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/child_response_collector.sv
// Collects responses from the child ports into one registered slot toward the
// parent, tagging each with its child index and counting forwarded responses.
module child_response_collector
    import collector_pkg::*;
#(
    parameter int NUM_CHILD = NUM_CHILD_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int IDX_W     = $clog2(NUM_CHILD)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CHILD-1:0]        in_valid,
    input  logic [NUM_CHILD*DATA_W-1:0] in_data,
    output logic [NUM_CHILD-1:0]        in_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [IDX_W-1:0]            out_idx,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            resp_count
);

    resp_t              slot;
    logic               slot_free;
    logic               any_grant;
    logic [NUM_CHILD-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [DATA_W-1:0]  sel_data;

    assign slot_free = !out_valid || out_ready;

    rr_arbiter #(
        .N     (NUM_CHILD),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .enable    (slot_free),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign in_ready  = grant;
    assign any_grant = |grant;

    // One-hot mux keeps in_data off the in_ready path entirely.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            slot       <= '0;
            resp_count <= '0;
        end else begin
            if (slot_free) begin
                out_valid <= any_grant;
                if (any_grant) begin
                    slot.data <= DATA_W_DEF'(sel_data);
                    slot.idx  <= IDX_W_DEF'(grant_idx);
                end
            end
            if (out_valid && out_ready && (resp_count != {CNT_W{1'b1}})) begin
                resp_count <= resp_count + 1'b1;
            end
        end
    end

    assign out_data = DATA_W'(slot.data);
    assign out_idx  = IDX_W'(slot.idx);

endmodule

// File: tb/tb_child_response_collector.sv
// Bench for child_response_collector: a transaction-level model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_child_response_collector;

    localparam int NC = 5;
    localparam int DW = 16;
    localparam int IW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     in_valid;
    logic [NC*DW-1:0]  in_data;
    logic [NC-1:0]     in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_idx;
    logic              out_ready;
    logic [15:0]       resp_count;

    int tests = 0;
    int fails = 0;

    // Model state: what the parent-facing slot must hold, and the fairness pointer.
    int  m_ptr;
    bit  m_valid;
    int  m_data;
    int  m_idx;
    int  m_cnt;
    // Decisions taken at the falling edge, applied at the next rising edge.
    int  pend_g;
    bit  pend_free;
    bit  pend_xfer;

    child_response_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_ready  (out_ready),
        .resp_count (resp_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_compare();
        int g;
        g = -1;
        pend_free = !m_valid || out_ready;
        if (pend_free) begin
            for (int k = 0; k < NC; k++) begin
                int c;
                c = (m_ptr + k) % NC;
                if (g < 0 && in_valid[c]) g = c;
            end
        end
        pend_g    = g;
        pend_xfer = m_valid && out_ready;
        if (rst_n) begin
            check("model in_ready", int'(in_ready), (g >= 0) ? (1 << g) : 0);
            check("model out_valid", int'(out_valid), int'(m_valid));
            if (m_valid) begin
                check("model out_data", int'(out_data), m_data);
                check("model out_idx", int'(out_idx), m_idx);
            end
            check("model resp_count", int'(resp_count), m_cnt);
        end
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_ptr   = 0;
            m_valid = 1'b0;
            m_data  = 0;
            m_idx   = 0;
            m_cnt   = 0;
        end else begin
            if (pend_xfer && m_cnt < 65535) m_cnt++;
            if (pend_free) begin
                m_valid = (pend_g >= 0);
                if (pend_g >= 0) begin
                    m_data = int'(in_data[pend_g*DW +: DW]);
                    m_idx  = pend_g;
                    m_ptr  = (pend_g + 1) % NC;
                end
            end
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge,
    // then return just after the edge so the caller can drive new inputs.
    task automatic tick();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_data(input int ch, input int value);
        in_data[ch*DW +: DW] = DW'(value);
    endtask

    task automatic sync_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_seq[7];
        exp_seq = '{0, 1, 2, 3, 4, 0, 1};

        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        pend_g    = -1;
        pend_free = 1'b0;
        pend_xfer = 1'b0;
        m_ptr = 0; m_valid = 1'b0; m_data = 0; m_idx = 0; m_cnt = 0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle out_valid", int'(out_valid), 0);
            check("idle in_ready", int'(in_ready), 0);
            check("idle resp_count", int'(resp_count), 0);
        end

        // Single response from child 3.
        set_data(3, 16'h1234);
        in_valid  = 5'b01000;
        out_ready = 1'b1;
        #1 check("single in_ready", int'(in_ready), 32'h08);
        tick();
        in_valid = '0;
        #1;
        check("single out_valid", int'(out_valid), 1);
        check("single out_data", int'(out_data), 32'h1234);
        check("single out_idx", int'(out_idx), 3);
        tick();
        check("single resp_count", int'(resp_count), 1);
        check("single drained", int'(out_valid), 0);
        // ptr now 4: child 4 beats child 0.
        in_valid = 5'b10001;
        #1 check("ptr after 3", int'(in_ready), 32'h10);
        tick();
        in_valid = '0;
        #1 check("ptr grant idx", int'(out_idx), 4);
        tick();
        check("count two", int'(resp_count), 2);

        // Fairness with all children valid; ptr is back at 0.
        for (int i = 0; i < NC; i++) set_data(i, 16'h00A0 + i);
        in_valid = '1;
        tick();
        for (int k = 0; k < 7; k++) begin
            check("rr out_valid", int'(out_valid), 1);
            check("rr out_idx", int'(out_idx), exp_seq[k]);
            check("rr out_data", int'(out_data), 32'hA0 + exp_seq[k]);
            tick();
        end
        in_valid = '0;
        tick();

        // Back-pressure: child 2 parked in the slot while child 0 waits.
        set_data(2, 16'h0055);
        set_data(0, 16'h0077);
        in_valid  = 5'b00100;
        out_ready = 1'b0;
        #1 check("bp load grant", int'(in_ready), 32'h04);
        tick();
        in_valid = 5'b00001;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp in_ready", int'(in_ready), 0);
            check("bp out_data", int'(out_data), 32'h55);
            check("bp out_idx", int'(out_idx), 2);
            tick();
        end
        out_ready = 1'b1;
        #1 check("bp release grant", int'(in_ready), 32'h01);
        tick();
        in_valid = '0;
        #1;
        check("bp next idx", int'(out_idx), 0);
        check("bp next data", int'(out_data), 32'h77);
        tick();

        // Saturation of resp_count.
        sync_reset();
        in_valid  = 5'b00001;
        out_ready = 1'b1;
        repeat (65540) tick();
        check("sat count", int'(resp_count), 32'hFFFF);
        repeat (3) tick();
        check("sat hold", int'(resp_count), 32'hFFFF);

        // Asynchronous reset in the middle of a burst.
        in_valid = '1;
        repeat (3) tick();
        check("pre-reset out_valid", int'(out_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async out_valid", int'(out_valid), 0);
        check("async resp_count", int'(resp_count), 0);
        tick();
        in_valid = 5'b00011;
        rst_n    = 1'b1;
        #1 check("post-reset grant", int'(in_ready), 32'h01);
        tick();
        check("post-reset idx", int'(out_idx), 0);
        in_valid = '0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
